hilo_div_ctrl: RTL
==================

# hilo_div_ctrl

Controller that sequences the multi-cycle divide engine on behalf of the MIPS core. It accepts DIV/DIVU issue from decode, latches the operands and launches the engine. It owns the architectural HI/LO registers and writes remainder to HI and quotient to LO on completion. It stalls the pipeline on any HI/LO access or new divide while a divide is in flight.

## Interface
Parameters:
- `W`, 32, operand/result width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  DIV/DIVU issued this cycle.
- `signed_op`  in  1  1 = DIV, 0 = DIVU; sampled with `start`.
- `a`, `b`  in  W  dividend, divisor; sampled with `start`.
- `mfhi`, `mflo`  in  1  HI/LO read requested this cycle.
- `mthi`, `mtlo`  in  1  HI/LO write requested this cycle.
- `wdata`  in  W  data for `mthi`/`mtlo`.
- `hi`, `lo`  out  W  architectural HI/LO, combinational from registers.
- `stall`  out  1  hold the requesting pipeline stage.
- `done`  out  1  one-cycle pulse when HI/LO are updated by a divide.
- `div_start`  out  1  one-cycle launch pulse to the engine.
- `div_signed`  out  1  registered copy of `signed_op`.
- `div_a`, `div_b`  out  W  registered operands, stable from launch until done.
- `div_done`  in  1  engine completion pulse.
- `div_q`, `div_r`  in  W  engine quotient and remainder, valid with `div_done`.

## Operation
- States: IDLE, LAUNCH, BUSY.
- IDLE:
  - `start=1`: latch `a`, `b`, `signed_op` → LAUNCH.
  - `mthi`/`mtlo`: write `wdata` at the edge. Both requests may coincide with `start`; the divide result overwrites later.
- LAUNCH: `div_start=1` for exactly this cycle → BUSY.
- BUSY:
  - Wait for `div_done`.
  - On `div_done`: LO←`div_q`, HI←`div_r`, `done=1` next cycle → IDLE.
- `stall = (state!=IDLE) & (start | mfhi | mflo | mthi | mtlo)`.
  - While stalled, requests are ignored, not queued. The pipeline re-presents them.
- `div_done` in IDLE or LAUNCH is ignored.
- `mthi` and `mtlo` in the same IDLE cycle both write.
- Reset (async, any state):
  - state IDLE; HI=LO=0; `div_a`=`div_b`=0; `div_signed`=0.
  - `div_start`=`done`=`stall`=0.
  - The engine shares `rst`. There is no abort path other than reset.

## Timing
- Accept at edge N. `div_start` is high in cycle N+1.
- If `div_done` arrives in cycle M, HI/LO are updated and `done` pulses in cycle M+1. `stall` drops in cycle M+1.
- End-to-end latency is engine latency + 2 cycles.
- Back-to-back: a `start` in cycle M+1 is accepted.
- `mfhi` in the `done` cycle returns the new value.

## Configuration
- `DIV_ZERO_BYPASS_EN` defined:
  - `start` with `b==0` never launches the engine.
  - IDLE → BUSY-equivalent completion next cycle: HI←`a`, LO←all ones, `done` pulses at N+1.
  - `div_start` stays 0.
- Not defined: `b==0` launches the engine normally; the result is whatever the engine returns.

## Structure
- Shared package `div_pkg`:
  - state enum `div_state_t` (IDLE, LAUNCH, BUSY).
  - `DIV_W` = 32.
  - `DIV_ZERO_LO` = 32'hFFFF_FFFF.
- One sub-module: `hilo_regs`, the HI/LO register pair with two write ports (mt* and divide completion; completion has priority). The FSM stays in the top.

## Test plan
- DIVU, a=100, b=7, engine done after 32 cycles → `div_start` at N+1; LO=14, HI=2; `done` one cycle; `stall` asserted for a `mflo` during BUSY.
- DIV, a=-7 (32'hFFFF_FFF9), b=2, engine returns q=-3, r=-1 → LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; `div_signed`=1 throughout.
- BUSY with `mthi`=1, `wdata`=5 → `stall`=1, HI unchanged; after done, `mthi` succeeds next cycle → HI=5.
- Assert `rst`=0 mid-BUSY → immediately HI=LO=0, state IDLE, `stall`=0. A subsequent `div_done` pulse has no effect.
- `DIV_ZERO_BYPASS_EN`, DIVU a=9, b=0 → no `div_start`; HI=9, LO=32'hFFFF_FFFF, `done` at N+1.
- `done` cycle followed by immediate `start` (a=50, b=5) → accepted without stall; LO=10, HI=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the HI/LO divide controller.
// Combinational only: no state lives here.
// No flow control: definitions only.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } div_state_t;

  localparam int          DIV_W       = 32;
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair with an mt* write port and a divide-completion port.
// Writes land at the clock edge; hi/lo are read straight from the flops.
// No backpressure: completion overrides a same-cycle mt* write to the same register.
module hilo_regs
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mthi_we,
  input  logic         mtlo_we,
  input  logic [W-1:0] wdata,
  input  logic         cpl_we,
  input  logic [W-1:0] cpl_hi,
  input  logic [W-1:0] cpl_lo,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  // HI/LO update: divide completion wins over a move-to write in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (cpl_we) begin
      hi <= cpl_hi;
      lo <= cpl_lo;
    end else begin
      if (mthi_we) hi <= wdata;
      if (mtlo_we) lo <= wdata;
    end
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Sequences the divide engine for DIV/DIVU and owns HI/LO; optional DIV_ZERO_BYPASS_EN short-circuits b==0.
// Latency: div_start at N+1 after accept; HI/LO and done one cycle after div_done (engine latency + 2).
// Backpressure: stall while a divide is in flight and any HI/LO access or new divide is requested; requests are dropped, not queued.
module hilo_div_ctrl
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mfhi,
  input  logic         mflo,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         stall,
  output logic         done,
  output logic         div_start,
  output logic         div_signed,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic         div_done,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r
);

  div_state_t   state;
  logic         idle;
  logic         zero_byp;
  logic         cpl_we;
  logic [W-1:0] cpl_hi;
  logic [W-1:0] cpl_lo;

  assign idle = (state == IDLE);

  // A divide by zero either completes locally or goes to the engine like any other
`ifdef DIV_ZERO_BYPASS_EN
  assign zero_byp = idle & start & (b == '0);
`else
  assign zero_byp = 1'b0;
`endif

  // Any HI/LO touch or new divide must wait while the engine owns the result
  assign stall = ~idle & (start | mfhi | mflo | mthi | mtlo);

  // Completion source: engine result in BUSY, or the synthetic divide-by-zero result
  always_comb begin
    cpl_we = 1'b0;
    cpl_hi = div_r;
    cpl_lo = div_q;
    if (state == BUSY && div_done) begin
      cpl_we = 1'b1;
    end
    if (zero_byp) begin
      cpl_we = 1'b1;
      cpl_hi = a;
      cpl_lo = '1;
    end
  end

  // Controller FSM with registered launch/done pulses and latched operands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      div_start  <= 1'b0;
      done       <= 1'b0;
      div_signed <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
    end else begin
      div_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_a      <= a;
            div_b      <= b;
            div_signed <= signed_op;
            if (zero_byp) begin
              done <= 1'b1;
            end else begin
              div_start <= 1'b1;
              state     <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          state <= BUSY;
        end
        BUSY: begin
          if (div_done) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  hilo_regs #(.W(W)) u_hilo_regs (
    .clk     (clk),
    .rst     (rst),
    .mthi_we (idle & mthi),
    .mtlo_we (idle & mtlo),
    .wdata   (wdata),
    .cpl_we  (cpl_we),
    .cpl_hi  (cpl_hi),
    .cpl_lo  (cpl_lo),
    .hi      (hi),
    .lo      (lo)
  );

endmodule
